tl_rx_vc_arbiter: RTL and testbench

Read-side scheduler for the RX virtual-channel buffers. It watches the six VC empty flags, picks one TLP class (posted, non-posted, completion) under PCIe producer/consumer ordering, and drives the per-class read control buses. A selected TLP is drained as one header read followed by its data beats, paced by per-class consumer ready. Tagged beat strobes (SOP/EOP/type) go to the downstream AXI-side consumers.

---
 rtl/tl_rx_vc_arbiter.sv | 177 +++++++++++++++++
 tb/tb_tl_rx_vc_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_rx_vc_arbiter.sv
// RX virtual-channel read scheduler: picks posted / non-posted / completion under producer-consumer
// ordering and drains one header read plus its data beats, paced by consumer ready.
module tl_rx_vc_arbiter #(
    parameter int unsigned DW               = 32,
    parameter int unsigned R_CTRL_BUS_WIDTH = 4,
    parameter int unsigned FLAGS_WIDTH      = 6,
    parameter int unsigned BEAT_DW          = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [FLAGS_WIDTH-1:0]      i_vc_r_empty_flags,
    input  logic [DW-1:0]               i_p_hdr_dw0,
    input  logic [DW-1:0]               i_np_hdr_dw0,
    input  logic [DW-1:0]               i_cpl_hdr_dw0,
    input  logic                        i_p_ready,
    input  logic                        i_np_ready,
    input  logic                        i_cpl_ready,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_r_posted_ctrl,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_r_non_posted_ctrl,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_r_completion_ctrl,
    output logic                        o_valid,
    output logic                        o_sop,
    output logic                        o_eop,
    output logic [1:0]                  o_tlp_type,
    output logic                        o_busy
);

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

    localparam logic [1:0] TypeNone = 2'b00;
    localparam logic [1:0] TypeP    = 2'b01;
    localparam logic [1:0] TypeNp   = 2'b10;
    localparam logic [1:0] TypeCpl  = 2'b11;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d, grant_new;
    logic        rr_q, rr_d;           // 0: NP wins next tie, 1: CPL wins next tie
    logic        has_data_q, has_data_d;
    logic [9:0]  len_q, len_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        valid_q, sop_q, eop_q;
    logic [1:0]  type_q;

    logic        p_elig, np_elig, cpl_elig;
    logic        sel_ready, sel_data_empty;
    logic        hdr_stb, data_stb;
    logic [DW-1:0] new_dw0;
    logic [10:0] len_eff;
    logic [5:0]  beats;
    logic [R_CTRL_BUS_WIDTH-1:0] stb_bus;
    logic        unused_dw0;

    assign unused_dw0 = ^{new_dw0[DW-1:31], new_dw0[29:10]};

    // NP and CPL may not pass a posted TLP, so both wait on an empty p_hdr
    assign p_elig   = ~i_vc_r_empty_flags[5];
    assign np_elig  = ~i_vc_r_empty_flags[3] & i_vc_r_empty_flags[5];
    assign cpl_elig = ~i_vc_r_empty_flags[1] & i_vc_r_empty_flags[5];

    always_comb begin
        grant_new = TypeNone;
        if (p_elig)                 grant_new = TypeP;
        else if (np_elig && cpl_elig) grant_new = rr_q ? TypeCpl : TypeNp;
        else if (np_elig)           grant_new = TypeNp;
        else if (cpl_elig)          grant_new = TypeCpl;
    end

    always_comb begin
        new_dw0 = '0;
        case (grant_new)
            TypeP:   new_dw0 = i_p_hdr_dw0;
            TypeNp:  new_dw0 = i_np_hdr_dw0;
            TypeCpl: new_dw0 = i_cpl_hdr_dw0;
            default: new_dw0 = '0;
        endcase
    end

    always_comb begin
        sel_ready      = 1'b0;
        sel_data_empty = 1'b1;
        case (grant_q)
            TypeP:   begin sel_ready = i_p_ready;   sel_data_empty = i_vc_r_empty_flags[4]; end
            TypeNp:  begin sel_ready = i_np_ready;  sel_data_empty = i_vc_r_empty_flags[2]; end
            TypeCpl: begin sel_ready = i_cpl_ready; sel_data_empty = i_vc_r_empty_flags[0]; end
            default: begin sel_ready = 1'b0;        sel_data_empty = 1'b1;                  end
        endcase
    end

    // Length 0 encodes 1024 DW
    assign len_eff = (len_q == 10'd0) ? 11'd1024 : {1'b0, len_q};
    assign beats   = 6'((len_eff + 11'(BEAT_DW - 1)) / 11'(BEAT_DW));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        has_data_d = has_data_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        hdr_stb    = 1'b0;
        data_stb   = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_new != TypeNone) begin
                    grant_d    = grant_new;
                    has_data_d = new_dw0[30];
                    len_d      = new_dw0[9:0];
                    state_d    = StHdr;
                    if (grant_new == TypeNp)  rr_d = 1'b1;
                    if (grant_new == TypeCpl) rr_d = 1'b0;
                end
            end
            StHdr: begin
                if (sel_ready) begin
                    hdr_stb = 1'b1;
                    if (has_data_q) begin
                        cnt_d   = beats;
                        state_d = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (sel_ready && !sel_data_empty) begin
                    data_stb = 1'b1;
                    cnt_d    = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stb_bus    = '0;
        stb_bus[0] = hdr_stb;
        stb_bus[1] = data_stb;
    end

    assign o_r_posted_ctrl     = (grant_q == TypeP)   ? stb_bus : '0;
    assign o_r_non_posted_ctrl = (grant_q == TypeNp)  ? stb_bus : '0;
    assign o_r_completion_ctrl = (grant_q == TypeCpl) ? stb_bus : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            grant_q    <= TypeNone;
            rr_q       <= 1'b0;
            has_data_q <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            type_q     <= TypeNone;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            has_data_q <= has_data_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            valid_q    <= hdr_stb | data_stb;
            sop_q      <= hdr_stb;
            eop_q      <= (hdr_stb & ~has_data_q) | (data_stb & (cnt_q == 6'd1));
            type_q     <= (hdr_stb | data_stb) ? grant_q : TypeNone;
        end
    end

    assign o_valid    = valid_q;
    assign o_sop      = sop_q;
    assign o_eop      = eop_q;
    assign o_tlp_type = type_q;
    assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_tl_rx_vc_arbiter.sv
// Directed self-checking bench for tl_rx_vc_arbiter.
module tb_tl_rx_vc_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  flags;
    logic [31:0] p_dw0, np_dw0, cpl_dw0;
    logic        p_rdy, np_rdy, cpl_rdy;
    logic [3:0]  p_ctrl, np_ctrl, cpl_ctrl;
    logic        valid, sop, eop, busy;
    logic [1:0]  ttype;
    logic [11:0] ctrl_all;
    logic [4:0]  beat;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign ctrl_all = {p_ctrl, np_ctrl, cpl_ctrl};
    assign beat     = {valid, sop, eop, ttype};

    tl_rx_vc_arbiter dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_vc_r_empty_flags  (flags),
        .i_p_hdr_dw0         (p_dw0),
        .i_np_hdr_dw0        (np_dw0),
        .i_cpl_hdr_dw0       (cpl_dw0),
        .i_p_ready           (p_rdy),
        .i_np_ready          (np_rdy),
        .i_cpl_ready         (cpl_rdy),
        .o_r_posted_ctrl     (p_ctrl),
        .o_r_non_posted_ctrl (np_ctrl),
        .o_r_completion_ctrl (cpl_ctrl),
        .o_valid             (valid),
        .o_sop               (sop),
        .o_eop               (eop),
        .o_tlp_type          (ttype),
        .o_busy              (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {p,np,cpl} ctrl with value v on class cls (1 P, 2 NP, 3 CPL)
    function automatic logic [11:0] ctl(input logic [1:0] cls, input logic [3:0] v);
        case (cls)
            2'd1:    return {v, 8'h00};
            2'd2:    return {4'h0, v, 4'h0};
            2'd3:    return {8'h00, v};
            default: return 12'h000;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rem;
        logic prev_stb, prev_last, emp;
        logic [1:0] cls;

        rst = 1'b1; flags = 6'h3F; p_dw0 = '0; np_dw0 = '0; cpl_dw0 = '0;
        p_rdy = 1'b1; np_rdy = 1'b1; cpl_rdy = 1'b1;
        #1;
        check("rst_ctrl", 32'(ctrl_all), 32'h0);
        check("rst_beat", 32'(beat), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        step(); step();
        rst = 1'b0;

        // Posted, Length 64, always ready
        p_dw0 = 32'h4000_0040; flags = 6'b001111;
        #1 check("p64_idle_ctrl", 32'(ctrl_all), 32'h0);
        step(); #1;
        check("p64_hdr_ctrl", 32'(ctrl_all), 32'(ctl(2'd1, 4'h1)));
        check("p64_hdr_busy", 32'(busy), 32'h1);
        flags = 6'b101111;
        step(); #1;
        check("p64_d0_ctrl", 32'(ctrl_all), 32'(ctl(2'd1, 4'h2)));
        check("p64_hbeat", 32'(beat), 32'b11001);
        step(); #1;
        check("p64_d1_ctrl", 32'(ctrl_all), 32'(ctl(2'd1, 4'h2)));
        check("p64_dbeat0", 32'(beat), 32'b10001);
        step(); #1;
        flags = 6'h3F;
        check("p64_end_ctrl", 32'(ctrl_all), 32'h0);
        check("p64_lastbeat", 32'(beat), 32'b10101);
        check("p64_end_busy", 32'(busy), 32'h0);
        step(); #1 check("p64_quiet", 32'(beat), 32'h0);

        // NP and CPL both pending, no data: round robin NP, CPL, NP, CPL
        np_dw0 = 32'h0; cpl_dw0 = 32'h0; flags = 6'b100101;
        for (int i = 0; i < 4; i++) begin
            cls = (i % 2 == 0) ? 2'd2 : 2'd3;
            step(); #1;
            check($sformatf("rr%0d_hdr", i), 32'(ctrl_all), 32'(ctl(cls, 4'h1)));
            step(); #1;
            if (i == 3) flags = 6'h3F;
            check($sformatf("rr%0d_beat", i), 32'(beat), 32'({3'b111, cls}));
        end
        step();

        // P arrives with CPL pending; P not ready stalls, CPL must wait
        p_dw0 = 32'h0; p_rdy = 1'b0; flags = 6'b001101;
        step(); #1;
        check("pstall_ctrl", 32'(ctrl_all), 32'h0);
        check("pstall_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            check($sformatf("pstall%0d_ctrl", i), 32'(ctrl_all), 32'h0);
            check($sformatf("pstall%0d_beat", i), 32'(beat), 32'h0);
        end
        p_rdy = 1'b1;
        #1 check("pgo_ctrl", 32'(ctrl_all), 32'(ctl(2'd1, 4'h1)));
        step(); #1;
        flags = 6'b101101;
        check("pgo_beat", 32'(beat), 32'b11101);
        step(); #1;
        check("cplafter_ctrl", 32'(ctrl_all), 32'(ctl(2'd3, 4'h1)));
        flags = 6'h3F;
        step(); #1 check("cplafter_beat", 32'(beat), 32'b11111);

        // Length 0 (1024 DW) with data empty toggling
        p_dw0 = 32'h4000_0000; flags = 6'b001111;
        step(); #1;
        check("l0_hdr_ctrl", 32'(ctrl_all), 32'(ctl(2'd1, 4'h1)));
        flags = 6'b101111;
        step();
        rem = 32; prev_stb = 1'b1; prev_last = 1'b0;
        for (int cyc = 0; cyc < 80 && rem > 0; cyc++) begin
            emp = (cyc % 2) != 0;
            flags[4] = emp;
            #1;
            check($sformatf("l0_c%0d_ctrl", cyc), 32'(ctrl_all),
                  32'(ctl(2'd1, emp ? 4'h0 : 4'h2)));
            check($sformatf("l0_c%0d_ve", cyc), 32'({valid, eop}), 32'({prev_stb, prev_last}));
            prev_stb  = !emp;
            prev_last = !emp && (rem == 1);
            if (!emp) rem--;
            step();
        end
        #1;
        flags = 6'h3F;
        check("l0_last_ve", 32'({valid, eop}), 32'b11);
        check("l0_end_busy", 32'(busy), 32'h0);
        check("l0_end_ctrl", 32'(ctrl_all), 32'h0);
        step();

        // Completion, Length 33 (2 beats), ready drops for 3 cycles mid-TLP
        cpl_dw0 = 32'h4000_0021; flags = 6'b111100;
        step(); #1;
        check("c33_hdr_ctrl", 32'(ctrl_all), 32'(ctl(2'd3, 4'h1)));
        flags = 6'b111110;
        step(); #1;
        check("c33_d0_ctrl", 32'(ctrl_all), 32'(ctl(2'd3, 4'h2)));
        check("c33_hbeat", 32'(beat), 32'b11011);
        step();
        cpl_rdy = 1'b0;
        #1;
        check("c33_st0_ctrl", 32'(ctrl_all), 32'h0);
        check("c33_st0_beat", 32'(beat), 32'b10011);
        check("c33_st0_busy", 32'(busy), 32'h1);
        for (int i = 1; i < 3; i++) begin
            step(); #1;
            check($sformatf("c33_st%0d_ctrl", i), 32'(ctrl_all), 32'h0);
            check($sformatf("c33_st%0d_beat", i), 32'(beat), 32'h0);
        end
        cpl_rdy = 1'b1;
        #1 check("c33_resume_ctrl", 32'(ctrl_all), 32'(ctl(2'd3, 4'h2)));
        step(); #1;
        check("c33_lastbeat", 32'(beat), 32'b10111);
        check("c33_end_busy", 32'(busy), 32'h0);
        flags = 6'h3F;

        // NP grant moves the RR pointer to CPL ahead of the reset test
        np_dw0 = 32'h0; flags = 6'b110111;
        step(); #1;
        check("np1_hdr_ctrl", 32'(ctrl_all), 32'(ctl(2'd2, 4'h1)));
        flags = 6'h3F;
        step(); #1 check("np1_beat", 32'(beat), 32'b11110);

        // Reset in DATA mid-TLP
        p_dw0 = 32'h4000_0040; flags = 6'b001111;
        step(); #1;
        check("rstm_hdr_ctrl", 32'(ctrl_all), 32'(ctl(2'd1, 4'h1)));
        flags = 6'b101111;
        step(); #1;
        check("rstm_d0_ctrl", 32'(ctrl_all), 32'(ctl(2'd1, 4'h2)));
        rst = 1'b1;
        #1;
        check("rstm_ctrl", 32'(ctrl_all), 32'h0);
        check("rstm_beat", 32'(beat), 32'h0);
        check("rstm_busy", 32'(busy), 32'h0);
        step(); step();
        rst = 1'b0; p_dw0 = 32'h0; flags = 6'b000101;
        step(); #1;
        check("rstm_p_ctrl", 32'(ctrl_all), 32'(ctl(2'd1, 4'h1)));
        check("rstm_p_busy", 32'(busy), 32'h1);
        flags = 6'b100101;
        step(); #1 check("rstm_p_beat", 32'(beat), 32'b11101);
        step(); #1;
        check("rstm_rr_np", 32'(ctrl_all), 32'(ctl(2'd2, 4'h1)));
        flags = 6'h3F;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
